// File: rtl/wb_retire_stage_if.sv
// M-stage inputs, register-file write port and retire-queue handshake of wb_retire_stage.
// With WB_PERF_EN defined the bundle also carries the 64-bit instret counter.
interface wb_retire_stage_if #(
  parameter int XLEN = 32
);
  logic            m_to_w_valid;
  logic            w_allow_in;
  logic [6:0]      M_opcode;
  logic [4:0]      M_rd;
  logic [XLEN-1:0] M_valE;
  logic [XLEN-1:0] m_valM;
  logic [XLEN-1:0] M_default_pc;
  logic [XLEN-1:0] M_cur_pc;
  logic [31:0]     M_instr;
  logic            M_commit;
  logic [XLEN-1:0] M_pred_pc;

  logic            w_valid;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  logic            retire_valid;
  logic            retire_ready;
  logic [XLEN-1:0] retire_pc;
  logic [31:0]     retire_instr;
  logic [XLEN-1:0] retire_pred_pc;
  logic            halt;
`ifdef WB_PERF_EN
  logic [63:0]     instret;
`endif

  modport master (
    output m_to_w_valid, M_opcode, M_rd, M_valE, m_valM, M_default_pc,
           M_cur_pc, M_instr, M_commit, M_pred_pc, retire_ready,
    input  w_allow_in, w_valid, rf_we, rf_waddr, rf_wdata, retire_valid,
           retire_pc, retire_instr, retire_pred_pc, halt
`ifdef WB_PERF_EN
    , input instret
`endif
  );

  modport slave (
    input  m_to_w_valid, M_opcode, M_rd, M_valE, m_valM, M_default_pc,
           M_cur_pc, M_instr, M_commit, M_pred_pc, retire_ready,
    output w_allow_in, w_valid, rf_we, rf_waddr, rf_wdata, retire_valid,
           retire_pc, retire_instr, retire_pred_pc, halt
`ifdef WB_PERF_EN
    , output instret
`endif
  );
endinterface

// File: rtl/wb_retire_stage.sv
// RV32I write-back stage: W register, opcode-based write-back select, DEPTH-entry retire queue, sticky ebreak halt.
// Optional macro WB_PERF_EN adds a 64-bit instret counter bumped once per retire-queue pop.
module wb_retire_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic              clk,
  input logic              rst_n,
  wb_retire_stage_if.slave bus
);
  localparam int PTR_W = CNT_W - 1;

  localparam logic [31:0] EBREAK    = 32'h0010_0073;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] pred_pc;
  } rec_t;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [XLEN-1:0] val_e;
    logic [XLEN-1:0] val_m;
    logic [XLEN-1:0] default_pc;
  } w_reg_t;

  w_reg_t           w_q, w_d;
  logic             w_valid_q, w_valid_d;
  logic             halt_q, halt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  rec_t             mem_q [DEPTH];
`ifdef WB_PERF_EN
  logic [63:0]      instret_q, instret_d;
`endif

  logic             retire_valid;
  logic             pop;
  logic             allow;
  logic             accept;
  logic             push;
  rec_t             head;
  logic [XLEN-1:0]  wb_data;
  logic             writes_rd;

  // A full queue still accepts when the head leaves on the same edge.
  always_comb begin
    retire_valid = (count_q != '0);
    pop          = retire_valid && bus.retire_ready;
    allow        = !halt_q && ((count_q < CNT_W'(DEPTH)) || pop);
    accept       = bus.m_to_w_valid && allow;
    push         = accept && bus.M_commit;
  end

  always_comb begin
    // NOTE: every signal gets its default first, so no path through the block leaves one unassigned and no latch is inferred.
    w_d       = w_q;
    w_valid_d = accept;
    halt_d    = halt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    if (accept) begin
      w_d.opcode     = bus.M_opcode;
      w_d.rd         = bus.M_rd;
      w_d.val_e      = bus.M_valE;
      w_d.val_m      = bus.m_valM;
      w_d.default_pc = bus.M_default_pc;
      if (bus.M_instr == EBREAK) begin
        halt_d = 1'b1;
      end
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

`ifdef WB_PERF_EN
  always_comb begin
    instret_d = pop ? instret_q + 64'd1 : instret_q;
  end
`endif

  // NOTE: state flops use non-blocking assignments so every flop samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q       <= '0;
      w_valid_q <= 1'b0;
      halt_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
`ifdef WB_PERF_EN
      instret_q <= '0;
`endif
    end else begin
      w_q       <= w_d;
      w_valid_q <= w_valid_d;
      halt_q    <= halt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
`ifdef WB_PERF_EN
      instret_q <= instret_d;
`endif
    end
  end

  // NOTE: queue storage is deliberately not reset; count and pointers decide which entries are live and the head is masked when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.M_cur_pc, bus.M_instr, bus.M_pred_pc};
    end
  end

  always_comb begin
    wb_data = w_q.val_e;
    case (w_q.opcode)
      OP_LOAD:         wb_data = w_q.val_m;
      OP_JAL, OP_JALR: wb_data = w_q.default_pc;
      default:         ;
    endcase

    writes_rd = 1'b1;
    case (w_q.opcode)
      OP_STORE, OP_BRANCH, OP_SYSTEM: writes_rd = 1'b0;
      default:                        ;
    endcase
  end

  assign head = mem_q[rd_ptr_q];

  assign bus.w_allow_in     = allow;
  assign bus.w_valid        = w_valid_q;
  assign bus.rf_we          = w_valid_q && (w_q.rd != 5'd0) && writes_rd;
  assign bus.rf_waddr       = w_q.rd;
  assign bus.rf_wdata       = wb_data;
  assign bus.retire_valid   = retire_valid;
  assign bus.retire_pc      = retire_valid ? head.pc      : '0;
  assign bus.retire_instr   = retire_valid ? head.instr   : '0;
  assign bus.retire_pred_pc = retire_valid ? head.pred_pc : '0;
  assign bus.halt           = halt_q;
`ifdef WB_PERF_EN
  assign bus.instret        = instret_q;
`endif
endmodule

// File: tb/tb_wb_retire_stage.sv
// Self-checking bench for wb_retire_stage: opcode vector table, directed full-queue/ebreak/reset sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_wb_retire_stage;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  localparam logic [31:0] EBREAK    = 32'h0010_0073;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_REG    = 7'b0110011;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  wb_retire_stage_if #(.XLEN(XLEN)) bus ();

  wb_retire_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        ready;
    logic        commit;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [31:0] val_e;
    logic [31:0] val_m;
    logic [31:0] dpc;
    logic [31:0] cpc;
    logic [31:0] instr;
    logic [31:0] ppc;
  } in_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ppc;
  } rec_t;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [31:0] val_e;
    logic [31:0] val_m;
    logic [31:0] dpc;
    logic        commit;
    logic        exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  int passed = 0;
  int total  = 0;

  rec_t        mq[$];
  logic        m_halt;
  logic        m_wvalid;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [63:0] m_instret;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] wb_value(input logic [6:0] op, input logic [31:0] ve,
                                           input logic [31:0] vm, input logic [31:0] dpc);
    if (op == OP_LOAD) return vm;
    if (op == OP_JAL || op == OP_JALR) return dpc;
    return ve;
  endfunction

  function automatic logic writes_reg(input logic [6:0] op, input logic [4:0] rd);
    return (rd != 5'd0) && (op != OP_STORE) && (op != OP_BRANCH) && (op != OP_SYSTEM);
  endfunction

  function automatic in_t mk(input logic v, input logic r, input logic c, input logic [6:0] op,
                             input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] instr);
    in_t s;
    s.valid  = v;
    s.ready  = r;
    s.commit = c;
    s.op     = op;
    s.rd     = rd;
    s.val_e  = pc ^ 32'h5A5A_0000;
    s.val_m  = pc ^ 32'h0000_A5A5;
    s.dpc    = pc + 32'd4;
    s.cpc    = pc;
    s.instr  = instr;
    s.ppc    = pc + 32'd8;
    return s;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_halt    = 1'b0;
    m_wvalid  = 1'b0;
    m_we      = 1'b0;
    m_waddr   = '0;
    m_wdata   = '0;
    m_instret = '0;
  endtask

  task automatic check_outputs();
    check("w_valid", bus.w_valid, m_wvalid);
    check("rf_we", bus.rf_we, m_we);
    if (m_we) begin
      check("rf_waddr", bus.rf_waddr, m_waddr);
      check("rf_wdata", bus.rf_wdata, m_wdata);
    end
    check("retire_valid", bus.retire_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("retire_pc", bus.retire_pc, mq[0].pc);
      check("retire_instr", bus.retire_instr, mq[0].instr);
      check("retire_pred_pc", bus.retire_pred_pc, mq[0].ppc);
    end
    check("halt", bus.halt, m_halt);
`ifdef WB_PERF_EN
    check("instret", bus.instret, m_instret);
`endif
  endtask

  // Entered at posedge+1; applies inputs, checks w_allow_in, crosses one edge and checks outputs at posedge+1.
  task automatic step(input in_t s);
    logic e_pop, e_allow, e_accept, e_push;
    rec_t r;
    bus.m_to_w_valid = s.valid;
    bus.retire_ready = s.ready;
    bus.M_commit     = s.commit;
    bus.M_opcode     = s.op;
    bus.M_rd         = s.rd;
    bus.M_valE       = s.val_e;
    bus.m_valM       = s.val_m;
    bus.M_default_pc = s.dpc;
    bus.M_cur_pc     = s.cpc;
    bus.M_instr      = s.instr;
    bus.M_pred_pc    = s.ppc;
    #1;
    e_pop    = (mq.size() != 0) && s.ready;
    e_allow  = !m_halt && ((mq.size() < DEPTH) || e_pop);
    e_accept = s.valid && e_allow;
    e_push   = e_accept && s.commit;
    check("w_allow_in", bus.w_allow_in, e_allow);
    @(posedge clk);
    if (e_pop) begin
      void'(mq.pop_front());
      m_instret = m_instret + 64'd1;
    end
    if (e_push) begin
      r.pc    = s.cpc;
      r.instr = s.instr;
      r.ppc   = s.ppc;
      mq.push_back(r);
    end
    m_wvalid = e_accept;
    m_we     = e_accept && writes_reg(s.op, s.rd);
    if (e_accept) begin
      m_waddr = s.rd;
      m_wdata = wb_value(s.op, s.val_e, s.val_m, s.dpc);
      if (s.instr == EBREAK) m_halt = 1'b1;
    end
    #1;
    check_outputs();
  endtask

  task automatic check_reset_state();
    check("rst_w_valid", bus.w_valid, 1'b0);
    check("rst_rf_we", bus.rf_we, 1'b0);
    check("rst_rf_wdata", bus.rf_wdata, 32'h0);
    check("rst_retire_valid", bus.retire_valid, 1'b0);
    check("rst_retire_pc", bus.retire_pc, 32'h0);
    check("rst_retire_instr", bus.retire_instr, 32'h0);
    check("rst_halt", bus.halt, 1'b0);
`ifdef WB_PERF_EN
    check("rst_instret", bus.instret, 64'h0);
`endif
  endtask

  task automatic release_reset();
    bus.m_to_w_valid = 1'b0;
    bus.retire_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.m_to_w_valid = 1'b0;
    bus.retire_ready = 1'b0;
    bus.M_commit     = 1'b0;
    rst_n = 1'b0;
    #3;
    check_reset_state();
    check("rst_allow", bus.w_allow_in, 1'b1);
    model_clear();
    release_reset();
  endtask

  vec_t vecs [10];
  logic [6:0] rand_ops [10];

  initial begin
    in_t s;
    logic [31:0] instr;

    vecs[0] = '{OP_IMM,    5'd5,  32'h0000_1234, 32'h0,         32'h4,         1'b1, 1'b1, 32'h0000_1234};
    vecs[1] = '{OP_LOAD,   5'd3,  32'h0000_0040, 32'hDEAD_BEEF, 32'h8,         1'b1, 1'b1, 32'hDEAD_BEEF};
    vecs[2] = '{OP_JAL,    5'd1,  32'h0000_0055, 32'h0000_0066, 32'h8000_0008, 1'b1, 1'b1, 32'h8000_0008};
    vecs[3] = '{OP_JALR,   5'd31, 32'h0000_0077, 32'h0000_0011, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0100};
    vecs[4] = '{OP_STORE,  5'd7,  32'h0000_0088, 32'h0000_0022, 32'h0000_0104, 1'b1, 1'b0, 32'h0};
    vecs[5] = '{OP_BRANCH, 5'd9,  32'h0000_0099, 32'h0000_0033, 32'h0000_0108, 1'b1, 1'b0, 32'h0};
    vecs[6] = '{OP_IMM,    5'd0,  32'h0000_00AA, 32'h0000_0044, 32'h0000_010C, 1'b1, 1'b0, 32'h0};
    vecs[7] = '{OP_LUI,    5'd12, 32'hABCD_0000, 32'h0000_0055, 32'h0000_0110, 1'b1, 1'b1, 32'hABCD_0000};
    vecs[8] = '{OP_SYSTEM, 5'd4,  32'h0000_00CC, 32'h0000_0066, 32'h0000_0114, 1'b0, 1'b0, 32'h0};
    vecs[9] = '{OP_REG,    5'd20, 32'h0000_0005, 32'h0000_0006, 32'h0000_0118, 1'b1, 1'b1, 32'h0000_0005};

    rand_ops = '{OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_SYSTEM, OP_IMM, OP_REG, OP_LUI, OP_AUIPC};

    model_clear();
    #2;
    do_reset();

    // Opcode table: one instruction per cycle with the consumer always ready.
    for (int i = 0; i < 10; i++) begin
      s = mk(1'b1, 1'b1, vecs[i].commit, vecs[i].op, vecs[i].rd, 32'h1000 + 32'(i * 4), 32'h0000_0013 + 32'(i << 20));
      s.val_e = vecs[i].val_e;
      s.val_m = vecs[i].val_m;
      s.dpc   = vecs[i].dpc;
      step(s);
      check("tbl_rf_we", bus.rf_we, vecs[i].exp_we);
      if (vecs[i].exp_we) check("tbl_rf_wdata", bus.rf_wdata, vecs[i].exp_wdata);
      check("tbl_retire_valid", bus.retire_valid, vecs[i].commit);
      if (vecs[i].commit) check("tbl_retire_pc", bus.retire_pc, 32'h1000 + 32'(i * 4));
    end
    step(mk(1'b0, 1'b1, 1'b0, OP_IMM, 5'd1, 32'h0, 32'h13));

    // Fill the queue with the consumer stalled, then accept and pop on the same edge.
    for (int k = 0; k < 4; k++) begin
      step(mk(1'b1, 1'b0, 1'b1, OP_IMM, 5'(k + 1), 32'h100 + 32'(k * 4), 32'h13));
    end
    check("full_allow_low", bus.w_allow_in, 1'b0);
    step(mk(1'b1, 1'b0, 1'b1, OP_IMM, 5'd8, 32'h1F0, 32'h13));
    check("full_no_accept", bus.w_valid, 1'b0);
    step(mk(1'b1, 1'b1, 1'b1, OP_IMM, 5'd9, 32'h200, 32'h13));
    check("full_push_pop_valid", bus.w_valid, 1'b1);
    check("full_push_pop_head", bus.retire_pc, 32'h104);
    step(mk(1'b0, 1'b1, 1'b0, OP_IMM, 5'd0, 32'h0, 32'h13));
    check("drain_1", bus.retire_pc, 32'h108);
    step(mk(1'b0, 1'b1, 1'b0, OP_IMM, 5'd0, 32'h0, 32'h13));
    check("drain_2", bus.retire_pc, 32'h10C);
    step(mk(1'b0, 1'b1, 1'b0, OP_IMM, 5'd0, 32'h0, 32'h13));
    check("drain_3", bus.retire_pc, 32'h200);
    step(mk(1'b0, 1'b1, 1'b0, OP_IMM, 5'd0, 32'h0, 32'h13));
    check("drain_empty", bus.retire_valid, 1'b0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      instr = $urandom;
      if (instr == EBREAK) instr = instr ^ 32'h1;
      s = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
             rand_ops[$urandom_range(0, 9)], 5'($urandom), $urandom & 32'hFFFF_FFFC, instr);
      s.val_e = $urandom;
      s.val_m = $urandom;
      s.dpc   = $urandom;
      step(s);
    end

    // ebreak: halt goes sticky, new instructions are refused, queued records still drain.
    do_reset();
    step(mk(1'b1, 1'b0, 1'b1, OP_IMM, 5'd6, 32'h300, 32'h0050_0313));
    step(mk(1'b1, 1'b0, 1'b1, OP_SYSTEM, 5'd0, 32'h304, EBREAK));
    check("ebreak_halt", bus.halt, 1'b1);
    check("ebreak_allow_low", bus.w_allow_in, 1'b0);
    step(mk(1'b1, 1'b1, 1'b1, OP_IMM, 5'd7, 32'h308, 32'h13));
    check("ebreak_ignored", bus.w_valid, 1'b0);
    check("ebreak_head_instr", bus.retire_instr, EBREAK);
    check("ebreak_head_pc", bus.retire_pc, 32'h304);
    step(mk(1'b1, 1'b1, 1'b1, OP_IMM, 5'd7, 32'h30C, 32'h13));
    check("ebreak_drained", bus.retire_valid, 1'b0);
    for (int k = 0; k < 3; k++) step(mk(1'b1, 1'b1, 1'b1, OP_IMM, 5'd7, 32'h310, 32'h13));
    check("halt_sticky", bus.halt, 1'b1);

    // Asynchronous reset with three records queued and halt set.
    do_reset();
    step(mk(1'b1, 1'b0, 1'b1, OP_IMM, 5'd1, 32'h400, 32'h13));
    step(mk(1'b1, 1'b0, 1'b1, OP_IMM, 5'd2, 32'h404, 32'h13));
    step(mk(1'b1, 1'b0, 1'b1, OP_SYSTEM, 5'd0, 32'h408, EBREAK));
    check("pre_rst_halt", bus.halt, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state();
    model_clear();
    release_reset();
    step(mk(1'b1, 1'b1, 1'b1, OP_IMM, 5'd3, 32'h500, 32'h13));
    check("post_rst_head", bus.retire_pc, 32'h500);
    step(mk(1'b0, 1'b1, 1'b0, OP_IMM, 5'd0, 32'h0, 32'h13));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
